// File: rtl/display_pkg.sv
// display_pkg: shared state type and widths for the display scheduler
package display_pkg;
    typedef enum logic [2:0] {SELECT, LOAD, SHIFT, COMMIT, WAIT} disp_state_t;
    localparam int IN_WIDTH = 12;
    localparam int BCD_DIGITS = 4;
    localparam int SHIFT_ITERS = 12;
endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if: source requests in, registered BCD digits and status out
interface display_scheduler_if #(parameter int NUM_SRC = 4);
    localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC*display_pkg::IN_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0] src_valid;
    logic next;
    logic hold;
    logic [SEL_W-1:0] sel;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic blank;
    logic busy;
    logic done;
    modport master(output src_data, src_valid, next, hold,
                   input sel, bcd3, bcd2, bcd1, bcd0, blank, busy, done);
    modport slave(input src_data, src_valid, next, hold,
                  output sel, bcd3, bcd2, bcd1, bcd0, blank, busy, done);
endinterface

// File: rtl/bcd_shift_unit.sv
// bcd_shift_unit: 12-iteration shift-add-3 binary to BCD converter
module bcd_shift_unit
    import display_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic [IN_WIDTH-1:0] bin,
    output logic busy,
    output logic done,
    output logic [BCD_DIGITS*4-1:0] bcd
);
    logic [BCD_DIGITS*4+IN_WIDTH-1:0] sr, adj;
    logic [3:0] iter;
    always_comb begin
        adj = sr;
        for (int i = 0; i < BCD_DIGITS; i++)
            adj[IN_WIDTH+4*i +: 4] = sr[IN_WIDTH+4*i +: 4] >= 4'd5 ? sr[IN_WIDTH+4*i +: 4] + 4'd3 : sr[IN_WIDTH+4*i +: 4];
    end
    // done flags the final iteration so the caller can leave SHIFT on the same edge
    assign done = busy && iter == 4'(SHIFT_ITERS - 1);
    assign bcd = sr[BCD_DIGITS*4+IN_WIDTH-1 -: BCD_DIGITS*4];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sr <= {{(BCD_DIGITS*4){1'b0}}, bin};
            iter <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sr <= adj << 1;
            iter <= iter + 4'd1;
            busy <= !done;
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin source sequencer feeding a 4-digit BCD display
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input logic clk,
    input logic reset_n,
    display_scheduler_if.slave bus
);
    localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    disp_state_t state;
    logic [SEL_W-1:0] hi, lo;
    logic [CNT_W-1:0] cnt;
    logic [IN_WIDTH-1:0] cur_data;
    logic [BCD_DIGITS*4-1:0] u_bcd;
    logic hi_ok, cur_ok, any_valid, next_req, wait_exit, pend, keep, u_busy, u_done;
    always_comb begin
        hi = bus.sel;
        lo = bus.sel;
        hi_ok = 1'b0;
        cur_ok = 1'b0;
        cur_data = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (j == int'(bus.sel)) cur_data = bus.src_data[IN_WIDTH*j +: IN_WIDTH];
            if (bus.src_valid[j]) begin
                lo = SEL_W'(j);
                if (j == int'(bus.sel)) cur_ok = 1'b1;
                if (j > int'(bus.sel)) begin
                    hi = SEL_W'(j);
                    hi_ok = 1'b1;
                end
            end
        end
    end
    assign any_valid = |bus.src_valid;
    assign next_req = pend | bus.next;
    assign wait_exit = state == WAIT && (cnt == CNT_W'(DWELL_CYCLES - 1) || next_req);
    bcd_shift_unit u_conv (
        .clk(clk), .reset_n(reset_n), .start(state == LOAD), .bin(cur_data),
        .busy(u_busy), .done(u_done), .bcd(u_bcd)
    );
    // keep starts set so the first pick after reset may be source 0 itself
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SELECT;
            bus.sel <= '0;
            {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} <= '0;
            bus.blank <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            pend <= 1'b0;
            keep <= 1'b1;
            cnt <= '0;
        end else begin
            bus.done <= state == COMMIT;
            bus.busy <= (state == SELECT && any_valid) || state == LOAD || (state == SHIFT && u_busy && !u_done);
            pend <= !wait_exit && next_req;
            case (state)
                SELECT: begin
                    bus.blank <= any_valid ? bus.blank : 1'b1;
                    bus.sel <= keep && cur_ok ? bus.sel : hi_ok ? hi : lo;
                    state <= any_valid ? LOAD : SELECT;
                end
                LOAD: state <= SHIFT;
                SHIFT: state <= u_done ? COMMIT : SHIFT;
                COMMIT: begin
                    {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} <= u_bcd;
                    bus.blank <= 1'b0;
                    cnt <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    keep <= wait_exit ? bus.hold && !next_req : keep;
                    state <= wait_exit ? SELECT : WAIT;
                end
                default: state <= SELECT;
            endcase
        end
    end
endmodule
